// File: rtl/psram_pkg.sv
// Shared definitions for the serial PSRAM responder and its initiator.
//
// Holds the supported opcodes, the wait-clock counts for the reads that use
// them, the FSM state encoding used on both sides of the link, and a decoder
// that turns an opcode into its transfer attributes.
package psram_pkg;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_FREAD  = 8'h0B;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_QWRITE = 8'h38;

  localparam int WAIT_FREAD = 8;
  localparam int WAIT_QREAD = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } psram_state_e;

  // Attributes of a decoded opcode. quad covers both the address and the
  // data phase: every quad opcode here is quad from the address on.
  typedef struct packed {
    logic       valid;
    logic       rd;
    logic       quad;
    logic [3:0] n_wait;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [7:0] op);
    op_info_t info;
    info = '0;
    case (op)
      OP_READ:   info = '{valid: 1'b1, rd: 1'b1, quad: 1'b0, n_wait: 4'd0};
      OP_FREAD:  info = '{valid: 1'b1, rd: 1'b1, quad: 1'b0, n_wait: 4'(WAIT_FREAD)};
      OP_QREAD:  info = '{valid: 1'b1, rd: 1'b1, quad: 1'b1, n_wait: 4'(WAIT_QREAD)};
      OP_WRITE:  info = '{valid: 1'b1, rd: 1'b0, quad: 1'b0, n_wait: 4'd0};
      OP_QWRITE: info = '{valid: 1'b1, rd: 1'b0, quad: 1'b1, n_wait: 4'd0};
      default:   info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/psram_qspi_responder_if.sv
// Serial PSRAM link as seen at the chip pins.
//
// rclk     serial clock (SPI mode 0), driven by the initiator
// rcs      chip select, active low, driven by the initiator
// data_i   bus lines as sampled by the responder; [0] is SI in SPI mode
// data_o   responder drive value; [1] is SO in SPI mode
// data_oe  per-line responder output enable; the pad wrapper builds the
//          tristate from data_o/data_oe
interface psram_qspi_responder_if;
  logic       rclk;
  logic       rcs;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic [3:0] data_oe;

  modport master (output rclk, rcs, data_i, input  data_o, data_oe);
  modport slave  (input  rclk, rcs, data_i, output data_o, data_oe);
endinterface

// File: rtl/psram_sync.sv
// Brings the asynchronous PSRAM link inputs into the clk domain.
//
// clk, rst      system clock, synchronous active-high reset
// rclk_i        raw serial clock      -> rclk_rise_o / rclk_fall_o pulses
// rcs_i         raw chip select       -> rcs_o (synchronised level)
// data_i        raw bus lines         -> data_o (synchronised)
//
// All three inputs go through the same two stages so the data word that
// sits next to a detected rclk rise is the one captured with it. The
// synchronised rcs resets low so a reset taken with rcs already low is not
// mistaken for the start of a frame.
module psram_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       rclk_i,
  input  logic       rcs_i,
  input  logic [3:0] data_i,
  output logic       rclk_rise_o,
  output logic       rclk_fall_o,
  output logic       rcs_o,
  output logic [3:0] data_o
);

  logic [2:0] rclk_q;   // [1:0] synchroniser, [2] previous value for edges
  logic [1:0] rcs_q;
  logic [3:0] data_q1, data_q2;

  // NOTE: sequential state uses non-blocking assignment so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rclk_q  <= '0;
      rcs_q   <= '0;
      data_q1 <= '0;
      data_q2 <= '0;
    end else begin
      rclk_q  <= {rclk_q[1:0], rclk_i};
      rcs_q   <= {rcs_q[0], rcs_i};
      data_q1 <= data_i;
      data_q2 <= data_q1;
    end
  end

  assign rclk_rise_o =  rclk_q[1] & ~rclk_q[2];
  assign rclk_fall_o = ~rclk_q[1] &  rclk_q[2];
  assign rcs_o       =  rcs_q[1];
  assign data_o      =  data_q2;

endmodule

// File: rtl/psram_qspi_responder.sv
// Target-side model of a serial PSRAM chip (SPI / QSPI).
//
// clk, rst   system clock (>= 8x rclk), synchronous active-high reset
// bus        PSRAM link, slave side (rclk, rcs, data_i, data_o, data_oe)
// active     high while a supported transaction is in progress
// cmd_err    one-clk pulse when an unsupported opcode is received
// last_cmd   most recently received opcode
//
// Reads serve bytes from an internal 2**ADDR_W byte array, writes fill it.
// Address bits above ADDR_W are dropped and the address wraps.
module psram_qspi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  psram_qspi_responder_if.slave  bus,
  output logic                   active,
  output logic                   cmd_err,
  output logic [7:0]             last_cmd
);

  localparam int DEPTH = 1 << ADDR_W;

  logic       rise, fall, rcs_s;
  logic [3:0] data_s;

  psram_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .rclk_i      (bus.rclk),
    .rcs_i       (bus.rcs),
    .data_i      (bus.data_i),
    .rclk_rise_o (rise),
    .rclk_fall_o (fall),
    .rcs_o       (rcs_s),
    .data_o      (data_s)
  );

  psram_state_e      state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;          // rises/falls within the phase
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sh_q, sh_d;            // read or write byte shifter
  logic              rd_q, rd_d;
  logic              quad_q, quad_d;
  logic [3:0]        wait_q, wait_d;
  logic              oe_on_q, oe_on_d;      // set on the first data fall
  logic [3:0]        data_o_q, data_o_d;
  logic              cmd_err_q, cmd_err_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic              armed_q, armed_d;      // rcs seen high since reset/frame

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_byte_q;             // prefetch of mem[addr_q]
  logic              mem_we;
  logic [7:0]        mem_wdata;

  op_info_t          info;
  logic [7:0]        rbyte, wbyte;
  logic [4:0]        addr_last, byte_last;

  assign addr_last = quad_q ? 5'd5 : 5'd23;
  assign byte_last = quad_q ? 5'd1 : 5'd7;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      sh_q       <= '0;
      rd_q       <= 1'b0;
      quad_q     <= 1'b0;
      wait_q     <= '0;
      oe_on_q    <= 1'b0;
      data_o_q   <= '0;
      cmd_err_q  <= 1'b0;
      last_cmd_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      sh_q       <= sh_d;
      rd_q       <= rd_d;
      quad_q     <= quad_d;
      wait_q     <= wait_d;
      oe_on_q    <= oe_on_d;
      data_o_q   <= data_o_d;
      cmd_err_q  <= cmd_err_d;
      last_cmd_q <= last_cmd_d;
      armed_q    <= armed_d;
    end
  end

  // NOTE: the array is deliberately left out of reset so its contents
  // survive rst and it can map onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
    rd_byte_q <= mem[addr_q];
  end

  always_comb begin
    // NOTE: every next-state value is defaulted to its register first, so
    // no branch below can leave a signal unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    sh_d       = sh_q;
    rd_d       = rd_q;
    quad_d     = quad_q;
    wait_d     = wait_q;
    oe_on_d    = oe_on_q;
    data_o_d   = data_o_q;
    cmd_err_d  = 1'b0;
    last_cmd_d = last_cmd_q;
    armed_d    = armed_q;
    mem_we     = 1'b0;
    mem_wdata  = sh_q;
    info       = '0;
    rbyte      = sh_q;
    wbyte      = sh_q;

    // rcs high overrides any rclk edge seen in the same cycle.
    if (rcs_s) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      oe_on_d  = 1'b0;
      data_o_d = '0;
      armed_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          // Only a frame whose start we saw is decoded; after a reset
          // taken mid-frame we wait for rcs to go high first.
          if (armed_q) begin
            state_d = ST_CMD;
            armed_d = 1'b0;
          end
        end

        ST_CMD: if (rise) begin
          cmd_d = {cmd_q[6:0], data_s[0]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            last_cmd_d = cmd_d;
            info       = decode_op(cmd_d);
            cnt_d      = '0;
            if (info.valid) begin
              state_d = ST_ADDR;
              rd_d    = info.rd;
              quad_d  = info.quad;
              wait_d  = info.n_wait;
            end else begin
              state_d   = ST_IGNORE;
              cmd_err_d = 1'b1;
            end
          end
        end

        ST_ADDR: if (rise) begin
          // Shifting MSB first into an ADDR_W register drops the unused
          // upper address bits on their own.
          addr_d = quad_q ? {addr_q[ADDR_W-5:0], data_s}
                          : {addr_q[ADDR_W-2:0], data_s[0]};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == addr_last) begin
            cnt_d = '0;
            if (wait_q != 4'd0) state_d = ST_WAIT;
            else                state_d = rd_q ? ST_RDATA : ST_WDATA;
          end
        end

        ST_WAIT: if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == {1'b0, wait_q} - 5'd1) begin
            cnt_d   = '0;
            state_d = ST_RDATA;
          end
        end

        ST_RDATA: if (fall) begin
          oe_on_d = 1'b1;
          // At a byte start take the prefetched byte and move the address
          // on, so rd_byte_q refills with the next byte while this one
          // is shifted out.
          if (cnt_q == 5'd0) begin
            rbyte  = rd_byte_q;
            addr_d = addr_q + ADDR_W'(1);
          end
          if (quad_q) begin
            data_o_d = rbyte[7:4];
            sh_d     = {rbyte[3:0], 4'h0};
          end else begin
            data_o_d = {2'b00, rbyte[7], 1'b0};
            sh_d     = {rbyte[6:0], 1'b0};
          end
          cnt_d = (cnt_q == byte_last) ? 5'd0 : cnt_q + 5'd1;
        end

        ST_WDATA: if (rise) begin
          wbyte = quad_q ? {sh_q[3:0], data_s} : {sh_q[6:0], data_s[0]};
          sh_d  = wbyte;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == byte_last) begin
            mem_we    = 1'b1;
            mem_wdata = wbyte;
            addr_d    = addr_q + ADDR_W'(1);
            cnt_d     = '0;
          end
        end

        ST_IGNORE: ;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.data_o  = data_o_q;
  assign bus.data_oe = (state_q == ST_RDATA && oe_on_q)
                       ? (quad_q ? 4'b1111 : 4'b0010) : 4'b0000;
  assign active      = (state_q != ST_IDLE) && (state_q != ST_IGNORE);
  assign cmd_err     = cmd_err_q;
  assign last_cmd    = last_cmd_q;

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Directed bench for psram_qspi_responder. The main process plays the
// initiator and queues the bytes each read must return; a monitor rebuilds
// bytes from the responder's drive at each rclk rise and scores them.
module tb_psram_qspi_responder;
  import psram_pkg::*;

  localparam int H = 5;   // clk cycles per rclk half period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active, cmd_err;
  logic [7:0] last_cmd;

  always #5 clk = ~clk;

  psram_qspi_responder_if bus ();

  psram_qspi_responder #(.ADDR_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .active   (active),
    .cmd_err  (cmd_err),
    .last_cmd (last_cmd)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [3:0] exp_mask = 4'b0000;
  bit         oe_allowed = 1'b0;
  int         oe_viol = 0;
  int         err_cnt = 0;
  logic [7:0] mon_acc = '0;
  int         mon_n = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: rebuild read bytes as the initiator would sample them.
  always @(posedge bus.rclk or posedge bus.rcs) begin : mon
    logic [7:0] nxt;
    int         n;
    logic [7:0] e;
    nxt = mon_acc;
    n   = mon_n;
    if (bus.rcs) begin
      nxt = '0;
      n   = 0;
    end else if (bus.data_oe != 4'b0000) begin
      if (bus.data_oe == 4'b1111) begin
        nxt = {nxt[3:0], bus.data_o};
        n   = n + 4;
      end else begin
        nxt = {nxt[6:0], bus.data_o[1]};
        n   = n + 1;
      end
      if (n == 8) begin
        n = 0;
        check("rd_oe_mask", 32'(bus.data_oe), 32'(exp_mask));
        check("rd_byte_expected", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rd_byte", 32'(nxt), 32'(e));
        end
      end
    end
    mon_acc <= nxt;
    mon_n   <= n;
  end

  always @(negedge clk) begin
    if (!rst && bus.data_oe != 4'b0000 && !oe_allowed) oe_viol <= oe_viol + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] d);
    bus.data_i = d;
    tick(H);
    bus.rclk = 1'b1;
    tick(H);
    bus.rclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]});
  endtask

  task automatic quad_byte(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic begin_txn(input logic [7:0] op);
    bus.rcs = 1'b0;
    tick(H);
    spi_byte(op);
    check("last_cmd", 32'(last_cmd), 32'(op));
  endtask

  task automatic send_addr(input logic [23:0] a, input bit quad);
    if (quad) for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
    else      for (int i = 23; i >= 0; i--) pulse({3'b000, a[i]});
  endtask

  task automatic end_txn();
    tick(H);
    bus.rcs = 1'b1;
    tick(3);
    check("oe_off_3clk", 32'(bus.data_oe), 32'(0));
    oe_allowed = 1'b0;
    tick(2 * H);
  endtask

  task automatic read_bytes(input logic [7:0] op, input logic [23:0] a,
                            input bit quad, input int n_wait,
                            input logic [3:0] mask, input int nbytes,
                            input logic [7:0] b0, input logic [7:0] b1);
    begin_txn(op);
    send_addr(a, quad);
    repeat (n_wait) pulse(4'h0);
    oe_allowed = 1'b1;
    exp_mask   = mask;
    exp_q.push_back(b0);
    if (nbytes > 1) exp_q.push_back(b1);
    repeat (nbytes * (quad ? 2 : 8)) pulse(4'h0);
    end_txn();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_oe"},  32'(bus.data_oe), 32'(0));
    check({tag, "_data_o"},   32'(bus.data_o),  32'(0));
    check({tag, "_active"},   32'(active),      32'(0));
    check({tag, "_cmd_err"},  32'(cmd_err),     32'(0));
    check({tag, "_last_cmd"}, 32'(last_cmd),    32'(0));
  endtask

  initial begin
    bus.rclk   = 1'b0;
    bus.rcs    = 1'b1;
    bus.data_i = 4'h0;
    rst = 1'b1;
    tick(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2 * H);

    // SPI write A5 3C at 0x10
    begin_txn(OP_WRITE);
    check("active_in_write", 32'(active), 32'(1));
    send_addr(24'h000010, 1'b0);
    spi_byte(8'hA5);
    spi_byte(8'h3C);
    end_txn();
    check("oe_quiet_write", 32'(oe_viol), 32'(0));

    // SPI read, fast read and quad read of the same bytes
    read_bytes(OP_READ,  24'h000010, 1'b0, 0,          4'b0010, 2, 8'hA5, 8'h3C);
    read_bytes(OP_QREAD, 24'h000010, 1'b1, WAIT_QREAD, 4'b1111, 2, 8'hA5, 8'h3C);
    read_bytes(OP_FREAD, 24'h000010, 1'b0, WAIT_FREAD, 4'b0010, 2, 8'hA5, 8'h3C);

    // Quad write across the top of the array, then read the wrap back
    begin_txn(OP_QWRITE);
    send_addr(24'h0003FF, 1'b1);
    quad_byte(8'h11);
    quad_byte(8'h22);
    end_txn();
    read_bytes(OP_READ,  24'h0003FF, 1'b0, 0, 4'b0010, 2, 8'h11, 8'h22);
    read_bytes(OP_QREAD, 24'h000000, 1'b1, WAIT_QREAD, 4'b1111, 1, 8'h22, 8'h00);

    // Unsupported opcode
    begin_txn(8'h9F);
    check("err_pulse_count", 32'(err_cnt), 32'(1));
    check("active_ignore", 32'(active), 32'(0));
    repeat (4) pulse(4'hF);
    end_txn();
    check("oe_quiet_ignore", 32'(oe_viol), 32'(0));

    // Known contents at 0x20, then a quad write cut after three nibbles:
    // only the first complete byte lands.
    begin_txn(OP_WRITE);
    send_addr(24'h000020, 1'b0);
    spi_byte(8'h5A);
    spi_byte(8'h6B);
    end_txn();
    begin_txn(OP_QWRITE);
    send_addr(24'h000020, 1'b1);
    pulse(4'hA);
    pulse(4'hB);
    pulse(4'hC);
    end_txn();

    // Reset in the middle of a read, with rcs held low throughout
    begin_txn(OP_READ);
    send_addr(24'h000020, 1'b0);
    oe_allowed = 1'b1;
    repeat (4) pulse(4'h0);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midrst");
    rst = 1'b0;
    oe_allowed = 1'b0;
    repeat (9) pulse(4'h1);
    check("active_after_midrst", 32'(active), 32'(0));
    check("last_cmd_after_midrst", 32'(last_cmd), 32'(0));
    end_txn();

    read_bytes(OP_READ, 24'h000020, 1'b0, 0, 4'b0010, 2, 8'hAB, 8'h6B);

    check("err_pulse_total", 32'(err_cnt), 32'(1));
    check("oe_quiet_total", 32'(oe_viol), 32'(0));
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
